// File: rtl/character_physics.sv
// character_physics: per-player fighter physics and animation state engine.
// All state advances once per frame_tick; hits may arrive on any cycle and
// are held until the next tick.
// Ports:
//   clk, reset (async, active-low), frame_tick (one-cycle pulse per frame)
//   buttons[4:0] = {down, attack, jump, right, left}; [7:5] unused
//   collision_left/right/top/bottom, is_grounded : contact flags
//   hit_valid, hit_vx, hit_vy, hit_stun          : incoming knockback
//   char_x, char_y    : integer pixel position (top-left)
//   state             : 0 IDLE .. 7 RESPAWN
//   facing_left, jumps_left, ko (one-cycle blast-zone pulse)
//   char_width, char_height : constant hitbox size
module character_physics #(
  parameter int FRAC           = 4,
  parameter int VEL_W          = 9,
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int CHAR_W         = 32,
  parameter int CHAR_H         = 48,
  parameter int SPAWN_X        = 304,
  parameter int SPAWN_Y        = 100,
  parameter int WALK_SPEED     = 32,
  parameter int GRAVITY        = 4,
  parameter int JUMP_VEL       = -64,
  parameter int MAX_FALL       = 96,
  parameter int MAX_JUMPS      = 2,
  parameter int LAND_FRAMES    = 4,
  parameter int ATTACK_FRAMES  = 12,
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic [7:0]       buttons,
  input  logic             collision_left,
  input  logic             collision_right,
  input  logic             collision_top,
  input  logic             collision_bottom,
  input  logic             is_grounded,
  input  logic             hit_valid,
  input  logic [VEL_W-1:0] hit_vx,
  input  logic [VEL_W-1:0] hit_vy,
  input  logic [5:0]       hit_stun,
  output logic [9:0]       char_x,
  output logic [9:0]       char_y,
  output logic [2:0]       state,
  output logic             facing_left,
  output logic [9:0]       char_width,
  output logic [9:0]       char_height,
  output logic [1:0]       jumps_left,
  output logic             ko
);

  localparam int POS_W = 10 + FRAC;
  localparam int SUM_W = POS_W + 2;

  localparam logic [POS_W-1:0] SPAWN_X_P = POS_W'(SPAWN_X << FRAC);
  localparam logic [POS_W-1:0] SPAWN_Y_P = POS_W'(SPAWN_Y << FRAC);
  localparam logic [POS_W-1:0] X_MAX_P   = POS_W'((SCREEN_W - CHAR_W) << FRAC);
  localparam logic signed [SUM_W-1:0] X_MAX_S = SUM_W'((SCREEN_W - CHAR_W) << FRAC);
  localparam logic [9:0] SCREEN_H_PX = 10'(SCREEN_H);

  localparam logic signed [VEL_W-1:0] WALK_V     = VEL_W'(WALK_SPEED);
  localparam logic signed [VEL_W-1:0] WALK_NV    = VEL_W'(-WALK_SPEED);
  localparam logic signed [VEL_W-1:0] GRAV_V     = VEL_W'(GRAVITY);
  localparam logic signed [VEL_W-1:0] JUMP_V     = VEL_W'(JUMP_VEL);
  localparam logic signed [VEL_W-1:0] MAX_FALL_V = VEL_W'(MAX_FALL);
  localparam logic signed [VEL_W-1:0] ONE_V      = VEL_W'(1);
  localparam logic signed [VEL_W:0]   VMAX_E     = (VEL_W+1)'((2 ** (VEL_W-1)) - 1);
  localparam logic signed [VEL_W:0]   VMIN_E     = (VEL_W+1)'(-(2 ** (VEL_W-1)));

  localparam logic [1:0] MAX_J = 2'(MAX_JUMPS);
  localparam logic [5:0] LAND_C = 6'(LAND_FRAMES);
  localparam logic [5:0] ATK_C  = 6'(ATTACK_FRAMES);
  localparam logic [5:0] RSP_C  = 6'(RESPAWN_FRAMES);

  typedef enum logic [2:0] {
    S_IDLE, S_WALK, S_JUMP, S_FALL, S_LAND, S_ATTACK, S_HITSTUN, S_RESPAWN
  } state_t;

  function automatic logic signed [VEL_W-1:0] sat_add(
    input logic signed [VEL_W-1:0] a,
    input logic signed [VEL_W-1:0] b
  );
    logic signed [VEL_W:0] s;
    s = {a[VEL_W-1], a} + {b[VEL_W-1], b};
    if (s > VMAX_E)      s = VMAX_E;
    else if (s < VMIN_E) s = VMIN_E;
    return s[VEL_W-1:0];
  endfunction

  state_t                  state_q, state_d;
  logic [POS_W-1:0]        px_q, px_d, py_q, py_d;
  logic signed [VEL_W-1:0] vx_q, vx_d, vy_q, vy_d;
  logic                    facing_q, facing_d;
  logic [1:0]              jumps_q, jumps_d;
  logic [5:0]              cnt_q, cnt_d;
  logic                    pend_q, pend_d;
  logic signed [VEL_W-1:0] hvx_q, hvx_d, hvy_q, hvy_d;
  logic [5:0]              hstun_q, hstun_d;
  logic                    jump_prev_q, jump_prev_d;
  logic                    ko_q, ko_d;

  logic                    grounded, jump_edge, dir_l, dir_r, hold;
  logic signed [SUM_W-1:0] x_sum, y_sum;
  logic                    unused_btn;

  assign grounded   = is_grounded | collision_bottom;
  assign jump_edge  = buttons[2] & ~jump_prev_q;
  assign dir_l      = buttons[0] & ~buttons[1];
  assign dir_r      = buttons[1] & ~buttons[0];
  assign unused_btn = ^buttons[7:5];

  always_comb begin
    state_d = state_q;   px_d = px_q;       py_d = py_q;
    vx_d = vx_q;         vy_d = vy_q;       facing_d = facing_q;
    jumps_d = jumps_q;   cnt_d = cnt_q;     pend_d = pend_q;
    hvx_d = hvx_q;       hvy_d = hvy_q;     hstun_d = hstun_q;
    jump_prev_d = jump_prev_q;
    ko_d = 1'b0;         hold = 1'b0;
    x_sum = '0;          y_sum = '0;

    // Hit latch runs every cycle; the newest hit overwrites any older one.
    if (hit_valid && state_q != S_RESPAWN) begin
      pend_d  = 1'b1;
      hvx_d   = hit_vx;
      hvy_d   = hit_vy;
      hstun_d = hit_stun;
    end

    if (frame_tick) begin
      jump_prev_d = buttons[2];

      if (state_d == S_RESPAWN) begin
        if (cnt_q <= 6'd1) begin
          cnt_d   = 6'd0;
          state_d = S_FALL;
        end else begin
          cnt_d = cnt_q - 6'd1;
          hold  = 1'b1;
        end
      end

      if (!hold) begin
        // Timed states expire before this frame's inputs are considered.
        if (state_d inside {S_LAND, S_ATTACK, S_HITSTUN}) begin
          if (cnt_d <= 6'd1) begin
            cnt_d   = 6'd0;
            state_d = grounded ? S_IDLE : S_FALL;
          end else begin
            cnt_d = cnt_d - 6'd1;
          end
        end

        if (pend_d) begin
          vx_d    = hvx_d;
          vy_d    = hvy_d;
          cnt_d   = hstun_d;
          state_d = S_HITSTUN;
        end

        if (state_d inside {S_IDLE, S_WALK, S_JUMP, S_FALL}) begin
          if (dir_r) begin
            vx_d = WALK_V;
            facing_d = 1'b0;
          end else if (dir_l) begin
            vx_d = WALK_NV;
            facing_d = 1'b1;
          end else begin
            vx_d = '0;
          end
        end else if (state_d == S_HITSTUN) begin
          if (vx_d[VEL_W-1])      vx_d = vx_d + ONE_V;
          else if (vx_d != '0)    vx_d = vx_d - ONE_V;
        end else begin
          vx_d = '0;
        end

        if (jump_edge && jumps_d != 2'd0 &&
            state_d inside {S_IDLE, S_WALK, S_JUMP, S_FALL}) begin
          vy_d    = JUMP_V;
          jumps_d = jumps_d - 2'd1;
          state_d = S_JUMP;
        end

        if (buttons[3] && state_d inside {S_IDLE, S_WALK}) begin
          state_d = S_ATTACK;
          cnt_d   = ATK_C;
        end

        if (!grounded || vy_d[VEL_W-1]) begin
          vy_d = sat_add(vy_d, GRAV_V);
          if (vy_d > MAX_FALL_V) vy_d = MAX_FALL_V;
        end
        // Fast-fall only once the character is already heading down.
        if (buttons[4] && state_d != S_HITSTUN && !grounded && !vy_d[VEL_W-1])
          vy_d = MAX_FALL_V;

        if (collision_left && vx_d[VEL_W-1])                   vx_d = '0;
        if (collision_right && !vx_d[VEL_W-1] && vx_d != '0)   vx_d = '0;
        if (collision_top && vy_d[VEL_W-1])                    vy_d = '0;

        x_sum = $signed({2'b00, px_q}) + $signed({{(SUM_W-VEL_W){vx_d[VEL_W-1]}}, vx_d});
        y_sum = $signed({2'b00, py_q}) + $signed({{(SUM_W-VEL_W){vy_d[VEL_W-1]}}, vy_d});
        if (x_sum[SUM_W-1])      px_d = '0;
        else if (x_sum > X_MAX_S) px_d = X_MAX_P;
        else                      px_d = x_sum[POS_W-1:0];
        py_d = y_sum[SUM_W-1] ? '0 : y_sum[POS_W-1:0];

        if (py_d[POS_W-1:FRAC] >= SCREEN_H_PX) begin
          ko_d     = 1'b1;
          px_d     = SPAWN_X_P;
          py_d     = SPAWN_Y_P;
          vx_d     = '0;
          vy_d     = '0;
          jumps_d  = MAX_J;
          facing_d = 1'b0;
          state_d  = S_RESPAWN;
          cnt_d    = RSP_C;
        end else begin
          if (grounded && !vy_d[VEL_W-1]) begin
            vy_d    = '0;
            jumps_d = MAX_J;
            if (state_d inside {S_JUMP, S_FALL}) begin
              state_d = S_LAND;
              cnt_d   = LAND_C;
            end
          end
          if (state_d == S_JUMP && !vy_d[VEL_W-1]) state_d = S_FALL;
          if (state_d inside {S_IDLE, S_WALK}) begin
            if (!grounded)        state_d = S_FALL;
            else if (vx_d != '0)  state_d = S_WALK;
            else                  state_d = S_IDLE;
          end
        end
      end
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      px_q        <= SPAWN_X_P;
      py_q        <= SPAWN_Y_P;
      vx_q        <= '0;
      vy_q        <= '0;
      facing_q    <= 1'b0;
      jumps_q     <= MAX_J;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      jump_prev_q <= 1'b1;
      ko_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      px_q        <= px_d;
      py_q        <= py_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      facing_q    <= facing_d;
      jumps_q     <= jumps_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      jump_prev_q <= jump_prev_d;
      ko_q        <= ko_d;
    end
  end

  // Hit payload is only consumed when pend_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    hvx_q   <= hvx_d;
    hvy_q   <= hvy_d;
    hstun_q <= hstun_d;
  end

  assign char_x      = px_q[POS_W-1:FRAC];
  assign char_y      = py_q[POS_W-1:FRAC];
  assign state       = state_q;
  assign facing_left = facing_q;
  assign jumps_left  = jumps_q;
  assign ko          = ko_q;
  assign char_width  = 10'(CHAR_W);
  assign char_height = 10'(CHAR_H);

endmodule

// File: tb/tb_character_physics.sv
module tb_character_physics;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] buttons = 8'h00;
  logic       collision_left = 1'b0, collision_right = 1'b0;
  logic       collision_top = 1'b0, collision_bottom = 1'b0;
  logic       is_grounded = 1'b1;
  logic       hit_valid = 1'b0;
  logic [8:0] hit_vx = '0, hit_vy = '0;
  logic [5:0] hit_stun = '0;
  logic [9:0] char_x, char_y, char_width, char_height;
  logic [2:0] state;
  logic       facing_left, ko;
  logic [1:0] jumps_left;

  character_physics dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .buttons(buttons),
    .collision_left(collision_left), .collision_right(collision_right),
    .collision_top(collision_top), .collision_bottom(collision_bottom),
    .is_grounded(is_grounded), .hit_valid(hit_valid), .hit_vx(hit_vx),
    .hit_vy(hit_vy), .hit_stun(hit_stun), .char_x(char_x), .char_y(char_y),
    .state(state), .facing_left(facing_left), .char_width(char_width),
    .char_height(char_height), .jumps_left(jumps_left), .ko(ko)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] btn;
    logic       gnd, cl, ct;
    int         x, y, st, j, f;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t mk(input logic [7:0] b, input logic g, input logic cl,
                              input logic ct, input int x, input int y,
                              input int st, input int j, input int f);
    vec_t v;
    v.btn = b; v.gnd = g; v.cl = cl; v.ct = ct;
    v.x = x; v.y = y; v.st = st; v.j = j; v.f = f;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read on the falling edge
  // after the tick's rising edge.
  task automatic tick(input logic [7:0] b, input logic g, input logic cl, input logic ct);
    @(negedge clk);
    buttons = b; is_grounded = g; collision_left = cl; collision_top = ct;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic send_hit(input logic [8:0] vx, input logic [8:0] vy, input logic [5:0] stun);
    @(negedge clk);
    hit_valid = 1'b1; hit_vx = vx; hit_vy = vy; hit_stun = stun;
    @(negedge clk);
    hit_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  bad;
    bit  found;

    for (int i = 0; i < 10; i++) tbl[i] = mk(8'h02, 1, 0, 0, 306 + 2*i, 100, 1, 2, 0);
    tbl[10] = mk(8'h00, 1, 0, 0, 324, 100, 0, 2, 0);
    tbl[11] = mk(8'h01, 1, 0, 0, 322, 100, 1, 2, 1);
    tbl[12] = mk(8'h01, 1, 1, 0, 322, 100, 0, 2, 1);
    tbl[13] = mk(8'h04, 1, 0, 0, 322,  96, 2, 1, 1);
    tbl[14] = mk(8'h00, 0, 0, 0, 322,  92, 2, 1, 1);
    tbl[15] = mk(8'h04, 0, 0, 0, 322,  89, 2, 0, 1);
    tbl[16] = mk(8'h00, 0, 0, 0, 322,  85, 2, 0, 1);
    tbl[17] = mk(8'h04, 0, 0, 0, 322,  82, 2, 0, 1);
    tbl[18] = mk(8'h00, 0, 0, 1, 322,  82, 3, 0, 1);
    tbl[19] = mk(8'h00, 0, 0, 0, 322,  82, 3, 0, 1);
    tbl[20] = mk(8'h10, 0, 0, 0, 322,  88, 3, 0, 1);
    tbl[21] = mk(8'h00, 1, 0, 0, 322,  94, 4, 2, 1);
    tbl[22] = mk(8'h00, 1, 0, 0, 322,  94, 4, 2, 1);
    tbl[23] = mk(8'h00, 1, 0, 0, 322,  94, 4, 2, 1);
    tbl[24] = mk(8'h00, 1, 0, 0, 322,  94, 4, 2, 1);
    tbl[25] = mk(8'h00, 1, 0, 0, 322,  94, 0, 2, 1);
    tbl[26] = mk(8'h08, 1, 0, 0, 322,  94, 5, 2, 1);
    tbl[27] = mk(8'h02, 1, 0, 0, 322,  94, 5, 2, 1);

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_x", int'(char_x), 304);
    check("rst_y", int'(char_y), 100);
    check("rst_state", int'(state), 0);
    check("rst_jumps", int'(jumps_left), 2);
    check("rst_facing", int'(facing_left), 0);
    check("rst_ko", int'(ko), 0);
    check("char_width", int'(char_width), 32);
    check("char_height", int'(char_height), 48);
    reset = 1'b1;

    // Walk, wall contact, double jump, ceiling, fast-fall, landing, attack
    for (int i = 0; i < 28; i++) begin
      tick(tbl[i].btn, tbl[i].gnd, tbl[i].cl, tbl[i].ct);
      check($sformatf("vec%0d_x", i), int'(char_x), tbl[i].x);
      check($sformatf("vec%0d_y", i), int'(char_y), tbl[i].y);
      check($sformatf("vec%0d_state", i), int'(state), tbl[i].st);
      check($sformatf("vec%0d_jumps", i), int'(jumps_left), tbl[i].j);
      check($sformatf("vec%0d_facing", i), int'(facing_left), tbl[i].f);
    end

    // Attack lock runs out after its remaining 11 frames
    for (int i = 0; i < 10; i++) begin
      tick(8'h00, 1, 0, 0);
      check($sformatf("attack_hold%0d", i), int'(state), 5);
    end
    tick(8'h00, 1, 0, 0);
    check("attack_end", int'(state), 0);

    // Mid-frame hit: latched, applied on the next tick
    send_hit(9'd80, 9'(-48), 6'd5);
    check("hit_not_yet", int'(state), 0);
    tick(8'h06, 1, 0, 0);
    check("hit_state", int'(state), 6);
    check("hit_x", int'(char_x), 326);
    check("hit_y", int'(char_y), 91);
    check("hit_facing", int'(facing_left), 1);
    tick(8'h06, 1, 0, 0);
    check("hit_x2", int'(char_x), 331);
    check("hit_y2", int'(char_y), 89);
    for (int i = 0; i < 3; i++) begin
      tick(8'h06, 1, 0, 0);
      check($sformatf("hitstun%0d", i), int'(state), 6);
    end
    check("hit_x5", int'(char_x), 346);
    check("hit_y5", int'(char_y), 83);
    tick(8'h06, 1, 0, 0);
    check("hitstun_end", int'(state), 1);
    check("hitstun_end_facing", int'(facing_left), 0);
    check("hitstun_end_x", int'(char_x), 348);

    // Blast zone: fall off the bottom
    found = 0;
    for (int i = 0; i < 150 && !found; i++) begin
      tick(8'h10, 0, 0, 0);
      if (ko) found = 1;
    end
    check("ko_seen", int'(found), 1);
    check("ko_x", int'(char_x), 304);
    check("ko_y", int'(char_y), 100);
    check("ko_state", int'(state), 7);
    check("ko_jumps", int'(jumps_left), 2);
    check("ko_facing", int'(facing_left), 0);
    @(negedge clk);
    check("ko_pulse_width", int'(ko), 0);

    // Respawn hold with a discarded hit
    bad = 0;
    for (int i = 0; i < 59; i++) begin
      if (i == 30) send_hit(9'd40, 9'(-40), 6'd9);
      tick(8'h12, 0, 0, 0);
      if (state != 3'd7 || char_x != 10'd304 || char_y != 10'd100 || ko) bad++;
    end
    check("respawn_hold_bad_ticks", bad, 0);
    tick(8'h00, 0, 0, 0);
    check("respawn_exit_state", int'(state), 3);
    check("respawn_exit_y", int'(char_y), 100);
    tick(8'h00, 0, 0, 0);
    check("respawn_hit_discarded", int'(state), 3);
    tick(8'h04, 0, 0, 0);
    check("air_jump_state", int'(state), 2);
    check("air_jump_jumps", int'(jumps_left), 1);
    check("air_jump_y", int'(char_y), 97);

    // Asynchronous reset mid-frame while jump is held
    @(negedge clk);
    buttons = 8'h04;
    #2 reset = 1'b0;
    #1;
    check("arst_x", int'(char_x), 304);
    check("arst_y", int'(char_y), 100);
    check("arst_state", int'(state), 0);
    check("arst_jumps", int'(jumps_left), 2);
    @(negedge clk);
    reset = 1'b1;
    tick(8'h04, 1, 0, 0);
    check("held_jump_no_fire", int'(state), 0);
    check("held_jump_y", int'(char_y), 100);
    tick(8'h00, 1, 0, 0);
    tick(8'h04, 1, 0, 0);
    check("jump_after_reset", int'(state), 2);
    check("jump_after_reset_y", int'(char_y), 96);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
